ex_mem_stage: RTL and testbench

Parametrised, elastic EX/MEM pipeline stage for the 64-bit pipelined core, placed between the execute stage (ALU, branch-target adder, forwarding mux B) and the memory stage. It carries writeback/memory control, branch target, ALU result/zero flag, store data and destination register. Unlike a plain always-load register, it adds a valid/ready handshake with a two-entry skid buffer, a synchronous flush for branch squashing, and bubble-safe control gating. It also keeps a saturating count of back-pressure cycles.

---
 rtl/ex_mem_stage.sv | 182 ++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: elastic EX/MEM pipeline register with a
// two-entry skid buffer, flush, bubble gating and stall counter.
module ex_mem_stage #(
  parameter int XLEN  = 64,
  parameter int REG_W = 5,
  parameter int WB_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,

  input  logic [WB_W-1:0]  WB,
  input  logic [2:0]       M,
  input  logic [XLEN-1:0]  Adder_Result,
  input  logic [XLEN-1:0]  ALU_Result,
  input  logic             ALU_Zero,
  input  logic [XLEN-1:0]  Forward_B_Mux_Result,
  input  logic [REG_W-1:0] rd,

  output logic             out_valid,
  input  logic             out_ready,

  output logic [WB_W-1:0]  WB_Out,
  output logic             Branch,
  output logic             MemWrite,
  output logic             MemRead,
  output logic [XLEN-1:0]  Adder_Result_Out,
  output logic [XLEN-1:0]  ALU_Result_Out,
  output logic             ALU_Zero_Out,
  output logic [XLEN-1:0]  Forward_B_Mux_Result_Out,
  output logic [REG_W-1:0] rd_out,

  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [WB_W-1:0]  wb;
    logic [2:0]       m;
    logic [XLEN-1:0]  add;
    logic [XLEN-1:0]  alu;
    logic             zero;
    logic [XLEN-1:0]  fwd;
    logic [REG_W-1:0] rd;
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  beat_t  in_beat;
  beat_t  main_q;
  beat_t  skid_q;

  logic   accept;
  logic   pop;
  logic   main_ld_in;
  logic   main_ld_skid;
  logic   skid_ld;

  assign in_beat.wb   = WB;
  assign in_beat.m    = M;
  assign in_beat.add  = Adder_Result;
  assign in_beat.alu  = ALU_Result;
  assign in_beat.zero = ALU_Zero;
  assign in_beat.fwd  = Forward_B_Mux_Result;
  assign in_beat.rd   = rd;

  // Readiness comes from registered state only, so the
  // upstream never sees a path from out_ready.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // Next state and entry-load selection; flush wins over all.
  always_comb begin
    state_d      = state_q;
    main_ld_in   = 1'b0;
    main_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d    = ONE;
          main_ld_in = 1'b1;
        end
      end
      ONE: begin
        unique case (1'b1)
          (accept & pop): begin
            main_ld_in = 1'b1;
          end
          (accept & ~pop): begin
            state_d = TWO;
            skid_ld = 1'b1;
          end
          (~accept & pop): begin
            state_d = EMPTY;
          end
          default: begin
            state_d = ONE;
          end
        endcase
      end
      TWO: begin
        if (pop) begin
          state_d      = ONE;
          main_ld_skid = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Main entry: fed from input or promoted from skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
    end else if (main_ld_skid) begin
      main_q <= skid_q;
    end else if (main_ld_in) begin
      main_q <= in_beat;
    end
  end

  // Skid entry absorbs the beat in flight when MEM stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q <= '0;
    end else if (skid_ld) begin
      skid_q <= in_beat;
    end
  end

  // Saturating count of cycles where MEM refuses a beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready) begin
      if (stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  // Control is gated so a bubble never writes anything.
  assign WB_Out   = out_valid ? main_q.wb : '0;
  assign Branch   = out_valid & main_q.m[2];
  assign MemWrite = out_valid & main_q.m[1];
  assign MemRead  = out_valid & main_q.m[0];

  assign Adder_Result_Out         = main_q.add;
  assign ALU_Result_Out           = main_q.alu;
  assign ALU_Zero_Out             = main_q.zero;
  assign Forward_B_Mux_Result_Out = main_q.fwd;
  assign rd_out                   = main_q.rd;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: vector table, directed corner cases and
// random traffic against a queue-based reference model.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [1:0]  WB;
  logic [2:0]  M;
  logic [63:0] Adder_Result;
  logic [63:0] ALU_Result;
  logic        ALU_Zero;
  logic [63:0] Forward_B_Mux_Result;
  logic [4:0]  rd;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  WB_Out;
  logic        Branch;
  logic        MemWrite;
  logic        MemRead;
  logic [63:0] Adder_Result_Out;
  logic [63:0] ALU_Result_Out;
  logic        ALU_Zero_Out;
  logic [63:0] Forward_B_Mux_Result_Out;
  logic [4:0]  rd_out;
  logic [15:0] stall_cnt;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [1:0]  s_WB_Out;
  logic        s_Branch;
  logic        s_MemWrite;
  logic        s_MemRead;
  logic [63:0] s_add;
  logic [63:0] s_alu;
  logic        s_zero;
  logic [63:0] s_fwd;
  logic [4:0]  s_rd;
  logic [3:0]  s_stall;

  always #5 clk = ~clk;

  ex_mem_stage u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush),
    .WB(WB), .M(M),
    .Adder_Result(Adder_Result),
    .ALU_Result(ALU_Result),
    .ALU_Zero(ALU_Zero),
    .Forward_B_Mux_Result(Forward_B_Mux_Result),
    .rd(rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .WB_Out(WB_Out), .Branch(Branch),
    .MemWrite(MemWrite), .MemRead(MemRead),
    .Adder_Result_Out(Adder_Result_Out),
    .ALU_Result_Out(ALU_Result_Out),
    .ALU_Zero_Out(ALU_Zero_Out),
    .Forward_B_Mux_Result_Out(Forward_B_Mux_Result_Out),
    .rd_out(rd_out),
    .stall_cnt(stall_cnt)
  );

  ex_mem_stage #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .flush(flush),
    .WB(WB), .M(M),
    .Adder_Result(Adder_Result),
    .ALU_Result(ALU_Result),
    .ALU_Zero(ALU_Zero),
    .Forward_B_Mux_Result(Forward_B_Mux_Result),
    .rd(rd),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .WB_Out(s_WB_Out), .Branch(s_Branch),
    .MemWrite(s_MemWrite), .MemRead(s_MemRead),
    .Adder_Result_Out(s_add),
    .ALU_Result_Out(s_alu),
    .ALU_Zero_Out(s_zero),
    .Forward_B_Mux_Result_Out(s_fwd),
    .rd_out(s_rd),
    .stall_cnt(s_stall)
  );

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [63:0] add;
    logic [63:0] alu;
    logic        zero;
    logic [63:0] fwd;
    logic [4:0]  rd;
  } mb_t;

  typedef struct {
    bit          iv;
    bit          ordy;
    logic [63:0] alu;
    bit          ev;
    bit          er;
    logic [63:0] ealu;
    int          estall;
  } vec_t;

  mb_t  mq[$];
  int   m_stall;
  int   m_sat;
  int   n_cmp;
  int   n_err;
  vec_t tbl[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic mb_t cur_beat();
    mb_t b;
    b.wb   = WB;
    b.m    = M;
    b.add  = Adder_Result;
    b.alu  = ALU_Result;
    b.zero = ALU_Zero;
    b.fwd  = Forward_B_Mux_Result;
    b.rd   = rd;
    return b;
  endfunction

  task automatic check_model();
    chk("in_ready", in_ready, mq.size() < 2);
    chk("out_valid", out_valid, mq.size() > 0);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("sat_stall_cnt", s_stall, m_sat);
    if (mq.size() > 0) begin
      chk("WB_Out", WB_Out, mq[0].wb);
      chk("Branch", Branch, mq[0].m[2]);
      chk("MemWrite", MemWrite, mq[0].m[1]);
      chk("MemRead", MemRead, mq[0].m[0]);
      chk("Adder_Out", Adder_Result_Out, mq[0].add);
      chk("ALU_Out", ALU_Result_Out, mq[0].alu);
      chk("Zero_Out", ALU_Zero_Out, mq[0].zero);
      chk("Fwd_Out", Forward_B_Mux_Result_Out, mq[0].fwd);
      chk("rd_out", rd_out, mq[0].rd);
    end else begin
      chk("bubble_ctrl",
          {WB_Out, Branch, MemWrite, MemRead}, 0);
    end
  endtask

  // One clock: the model steps on the same edge as the DUT.
  task automatic cycle();
    bit  acc;
    bit  pp;
    bit  stl;
    bit  fl;
    mb_t b;
    acc = in_valid && (mq.size() < 2);
    pp  = (mq.size() > 0) && out_ready;
    stl = (mq.size() > 0) && !out_ready;
    fl  = flush;
    b   = cur_beat();
    @(posedge clk);
    #1;
    if (stl) begin
      if (m_stall < 65535) m_stall++;
      if (m_sat < 15) m_sat++;
    end
    if (fl) begin
      mq.delete();
    end else begin
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(b);
    end
    check_model();
  endtask

  task automatic set_data(input logic [63:0] v);
    ALU_Result           = v;
    Adder_Result         = v + 64'd100;
    Forward_B_Mux_Result = ~v;
    ALU_Zero             = (v == 64'd0);
    rd                   = v[4:0];
  endtask

  task automatic add_vec(input bit iv, input bit ordy,
                         input logic [63:0] alu,
                         input bit ev, input bit er,
                         input logic [63:0] ealu,
                         input int estall);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.alu = alu;
    v.ev = ev; v.er = er; v.ealu = ealu;
    v.estall = estall;
    tbl.push_back(v);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_stall = 0;
    m_sat = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    WB = 2'b00;
    M = 3'b000;
    set_data(64'd0);

    for (int i = 1; i <= 8; i++)
      add_vec(1, 1, i, 1, 1, i, 0);
    add_vec(1, 0, 9, 1, 0, 8, 1);
    for (int i = 2; i <= 5; i++)
      add_vec(1, 0, 10, 1, 0, 8, i);
    add_vec(1, 1, 10, 1, 1, 9, 5);
    add_vec(1, 1, 10, 1, 1, 10, 5);
    add_vec(0, 1, 11, 0, 1, 0, 5);

    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.ctrl", {WB_Out, Branch, MemWrite, MemRead}, 0);
    chk("rst.alu", ALU_Result_Out, 0);
    chk("rst.stall", stall_cnt, 0);
    rst_n = 1'b1;

    WB = 2'b11;
    M  = 3'b001;
    foreach (tbl[i]) begin
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      set_data(tbl[i].alu);
      cycle();
      chk($sformatf("tbl%0d.out_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d.in_ready", i), in_ready, tbl[i].er);
      chk($sformatf("tbl%0d.MemRead", i), MemRead, tbl[i].ev);
      chk($sformatf("tbl%0d.stall", i), stall_cnt, tbl[i].estall);
      if (tbl[i].ev)
        chk($sformatf("tbl%0d.alu", i), ALU_Result_Out, tbl[i].ealu);
    end

    M = 3'b010;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_data(64'h55);
    cycle();
    chk("bubble.MemWrite", MemWrite, 0);
    in_valid = 1'b1;
    cycle();
    chk("beat.MemWrite", MemWrite, 1);
    in_valid = 1'b0;
    cycle();
    chk("after.MemWrite", MemWrite, 0);

    out_ready = 1'b0;
    in_valid = 1'b1;
    set_data(64'h11);
    cycle();
    set_data(64'h22);
    cycle();
    chk("fill.in_ready", in_ready, 0);
    flush = 1'b1;
    set_data(64'hDEAD);
    cycle();
    chk("flush2.out_valid", out_valid, 0);
    chk("flush2.MemWrite", MemWrite, 0);
    chk("flush2.in_ready", in_ready, 1);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      cycle();
      chk("post_flush.out_valid", out_valid, 0);
    end
    in_valid = 1'b1;
    out_ready = 1'b0;
    set_data(64'h33);
    cycle();
    flush = 1'b1;
    set_data(64'hBEEF);
    cycle();
    chk("flush1.out_valid", out_valid, 0);
    flush = 1'b0;
    in_valid = 1'b0;
    cycle();
    chk("flush1.drop", out_valid, 0);

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      WB        = 2'($urandom);
      M         = 3'($urandom);
      set_data({$urandom, $urandom});
      cycle();
    end
    flush = 1'b0;

    in_valid = 1'b1;
    out_ready = 1'b0;
    M = 3'b010;
    repeat (3) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst.out_valid", out_valid, 0);
    chk("mrst.in_ready", in_ready, 1);
    chk("mrst.MemWrite", MemWrite, 0);
    chk("mrst.stall", stall_cnt, 0);
    chk("mrst.alu", ALU_Result_Out, 0);
    mq.delete();
    m_stall = 0;
    m_sat = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    in_valid = 1'b1;
    out_ready = 1'b0;
    set_data(64'h77);
    repeat (10) cycle();
    chk("sat.partial", s_stall, 9);
    repeat (11) cycle();
    chk("sat.max", s_stall, 15);
    chk("sat.wide", stall_cnt, 20);
    cycle();
    chk("sat.hold", s_stall, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
